// File: rtl/teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
// Shared types and helpers for the 4x4 keypad reader.
//   estado_t     : reader FSM states
//   N_REBOTE_DEF : default debounce length in clk cycles (10 ms at 27 MHz)
//   onehot_idx   : bit position of the lowest set bit of a 4-bit vector
//   es_onehot    : 1 when exactly one bit of a 4-bit vector is set
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package teclado_pkg;

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    REBOTE     = 2'd1,
    PRESIONADO = 2'd2,
    SOLTAR     = 2'd3
  } estado_t;

  localparam int N_REBOTE_DEF = 270000;

  // Lowest set bit wins, so this doubles as the column priority encoder.
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic es_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// -----------------------------------------------------------------------------
// sincronizador
// Two-flop synchronizer for asynchronous level inputs.
//   clk : system clock
//   rst : asynchronous active-low reset (outputs clear to 0)
//   i_d : asynchronous input vector, W bits
//   o_q : synchronized vector, two clk cycles of delay
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sincronizador #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/lector_teclado.sv
// -----------------------------------------------------------------------------
// lector_teclado
// 4x4 matrix keypad reader. Synchronizes fila/columna, debounces the press
// and the release, and reports the key code 4*row + column with a one-cycle
// strobe. detener asks the row ring counter to freeze while a key is active.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   fila         : one-hot row driven by the ring counter
//   columna      : raw column lines, active-high, asynchronous
//   tecla        : last accepted key code, held until the next one
//   tecla_valida : one-cycle pulse when tecla is updated
//   detener      : 1 = freeze the ring counter on the current row
//
// state      | meaning
// -----------+--------------------------------------------------------------
// REPOSO     | idle, waiting for any column with a valid one-hot row
// REBOTE     | captured key must stay stable for N_REBOTE cycles
// PRESIONADO | single cycle: load tecla and strobe tecla_valida
// SOLTAR     | all columns must stay low N_REBOTE cycles before re-arming
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lector_teclado
  import teclado_pkg::*;
#(
  parameter int N_REBOTE = N_REBOTE_DEF,
  parameter int W_CNT    = $clog2(N_REBOTE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  input  logic [3:0] columna,
  output logic [3:0] tecla,
  output logic       tecla_valida,
  output logic       detener
);

  localparam logic [W_CNT-1:0] CNT_FIN = W_CNT'(N_REBOTE - 1);

  logic [3:0]       w_col_s;
  logic [3:0]       w_fila_s;

  estado_t          r_estado;
  logic [W_CNT-1:0] r_cnt;
  logic [3:0]       r_fila_cap;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_codigo;
  logic [3:0]       r_tecla;
  logic             r_valida;
  logic             r_detener;

  estado_t          w_estado_sig;
  logic [W_CNT-1:0] w_cnt_sig;
  logic             w_captura;

  // Both paths get the same two-flop delay so row and column stay aligned.
  sincronizador #(.W(4)) u_sinc_col (
    .clk (clk),
    .rst (rst),
    .i_d (columna),
    .o_q (w_col_s)
  );

  sincronizador #(.W(4)) u_sinc_fila (
    .clk (clk),
    .rst (rst),
    .i_d (fila),
    .o_q (w_fila_s)
  );

  always_comb begin
    w_estado_sig = r_estado;
    w_cnt_sig    = r_cnt;
    w_captura    = 1'b0;
    case (r_estado)
      REPOSO: begin
        if ((w_col_s != 4'd0) && es_onehot(w_fila_s)) begin
          w_captura    = 1'b1;
          w_cnt_sig    = '0;
          w_estado_sig = REBOTE;
        end
      end
      REBOTE: begin
        // Only the captured column matters; a row change means the ring
        // counter moved on before detener took effect.
        if (!w_col_s[r_col_idx] || (w_fila_s != r_fila_cap)) begin
          w_estado_sig = REPOSO;
        end else if (r_cnt == CNT_FIN) begin
          w_estado_sig = PRESIONADO;
        end else begin
          w_cnt_sig = r_cnt + W_CNT'(1);
        end
      end
      PRESIONADO: begin
        w_cnt_sig    = '0;
        w_estado_sig = SOLTAR;
      end
      SOLTAR: begin
        // Any column high restarts the release window.
        if (w_col_s != 4'd0) begin
          w_cnt_sig = '0;
        end else if (r_cnt == CNT_FIN) begin
          w_estado_sig = REPOSO;
        end else begin
          w_cnt_sig = r_cnt + W_CNT'(1);
        end
      end
      default: begin
        w_estado_sig = REPOSO;
        w_cnt_sig    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_estado   <= REPOSO;
      r_cnt      <= '0;
      r_fila_cap <= 4'd0;
      r_col_idx  <= 2'd0;
      r_codigo   <= 4'd0;
      r_tecla    <= 4'd0;
      r_valida   <= 1'b0;
      r_detener  <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_cnt     <= w_cnt_sig;
      r_valida  <= (r_estado == PRESIONADO);
      r_detener <= (w_estado_sig != REPOSO);
      if (w_captura) begin
        r_fila_cap <= w_fila_s;
        r_col_idx  <= onehot_idx(w_col_s);
        r_codigo   <= {onehot_idx(w_fila_s), onehot_idx(w_col_s)};
      end
      if (r_estado == PRESIONADO) begin
        r_tecla <= r_codigo;
      end
    end
  end

  assign tecla        = r_tecla;
  assign tecla_valida = r_valida;
  assign detener      = r_detener;

endmodule

// File: tb/tb_lector_teclado.sv
`timescale 1ns/1ps
module tb_lector_teclado;

  localparam int NR = 4;

  logic       clk;
  logic       rst;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       detener;

  int total;
  int bad;
  int pulses;
  int exp_tecla;

  lector_teclado #(.N_REBOTE(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .fila         (fila),
    .columna      (columna),
    .tecla        (tecla),
    .tecla_valida (tecla_valida),
    .detener      (detener)
  );

  initial clk = 1'b0;
  always #18.5 clk = ~clk;

  always @(negedge clk) begin
    if (tecla_valida === 1'b1) pulses++;
  end

  function automatic int lowest_bit(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_fila(input logic [3:0] f);
    fila = f;
    repeat (4) @(posedge clk);
  endtask

  // Press key pattern c in the current (already stable) row f for d cycles,
  // then release. Expectations come from the timing rules:
  //  - detection always happens at edge 3 (columna sampled at edge 1)
  //  - accepted only if columna stayed high through edge NR+1
  //  - strobe seen after edge NR+4
  //  - detener falls at the abort edge (d+3) or after NR release edges
  task automatic run_press(input logic [3:0] f, input logic [3:0] c,
                           input int d, input string nm);
    bit acc;
    int code, fall, rel0;
    acc  = (d >= NR + 1);
    code = 4 * lowest_bit(f) + lowest_bit(c);
    rel0 = (d + 3 > NR + 5) ? d + 3 : NR + 5;
    fall = acc ? rel0 + NR - 1 : d + 3;
    @(posedge clk); #1 columna = c;
    for (int k = 1; k <= fall + 3; k++) begin
      @(posedge clk); #1;
      if (k == d) columna = 4'd0;
      @(negedge clk);
      total++;
      if (detener !== ((k >= 3 && k < fall) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL %s detener edge=%0d got=%b want=%b", nm, k, detener,
                 (k >= 3 && k < fall));
      end
      total++;
      if (tecla_valida !== ((acc && k == NR + 4) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL %s tecla_valida edge=%0d got=%b want=%b", nm, k,
                 tecla_valida, (acc && k == NR + 4));
      end
      if (acc && k == NR + 4) begin
        exp_tecla = code;
        total++;
        if (tecla !== 4'(code)) begin
          bad++;
          $display("FAIL %s tecla at strobe got=%0d want=%0d", nm, tecla, code);
        end
      end
    end
    total++;
    if (tecla !== 4'(exp_tecla)) begin
      bad++;
      $display("FAIL %s tecla held got=%0d want=%0d", nm, tecla, exp_tecla);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; fila = 4'd0; columna = 4'd0;
    repeat (3) @(posedge clk);
    #5 rst = 1'b0;
    #1;
    total++;
    if ({tecla, tecla_valida, detener} !== 6'd0) begin
      bad++;
      $display("FAIL reset_immediate got=%b want=000000", {tecla, tecla_valida, detener});
    end
    exp_tecla = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({tecla, tecla_valida, detener} !== 6'd0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=000000", i, {tecla, tecla_valida, detener});
      end
    end
  endtask

  task automatic test_single_press;
    set_fila(4'b0100);
    run_press(4'b0100, 4'b0010, 20, "single_press");
    total++;
    if (tecla !== 4'd9) begin
      bad++;
      $display("FAIL single_press code got=%0d want=9", tecla);
    end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pulses;
    run_press(4'b0100, 4'b0010, 2, "bounce");
    total++;
    if (pulses != p0) begin
      bad++;
      $display("FAIL bounce pulses got=%0d want=0", pulses - p0);
    end
  endtask

  task automatic test_long_hold;
    int p0;
    p0 = pulses;
    @(posedge clk); #1 columna = 4'b0010;
    repeat (50) @(posedge clk);
    #1 columna = 4'd0;
    repeat (3) @(posedge clk);
    #1 columna = 4'b0010;
    @(negedge clk);
    total++;
    if (detener !== 1'b1) begin
      bad++;
      $display("FAIL long_hold detener_short_release got=%b want=1", detener);
    end
    repeat (20) @(posedge clk);
    #1 columna = 4'd0;
    repeat (NR + 8) @(posedge clk);
    @(negedge clk);
    exp_tecla = 9;
    total++;
    if (pulses - p0 != 1) begin
      bad++;
      $display("FAIL long_hold pulses got=%0d want=1", pulses - p0);
    end
    total++;
    if (detener !== 1'b0) begin
      bad++;
      $display("FAIL long_hold detener_after_release got=%b want=0", detener);
    end
    total++;
    if (tecla !== 4'd9) begin
      bad++;
      $display("FAIL long_hold tecla got=%0d want=9", tecla);
    end
    p0 = pulses;
    run_press(4'b0100, 4'b0100, 10, "long_hold_repress");
    total++;
    if (pulses - p0 != 1) begin
      bad++;
      $display("FAIL long_hold_repress pulses got=%0d want=1", pulses - p0);
    end
  endtask

  task automatic test_two_keys;
    set_fila(4'b0001);
    run_press(4'b0001, 4'b1010, 10, "two_keys");
    total++;
    if (tecla !== 4'd1) begin
      bad++;
      $display("FAIL two_keys code got=%0d want=1", tecla);
    end
  endtask

  task automatic test_no_row;
    logic [3:0] rows [2];
    int p0;
    rows[0] = 4'b0000;
    rows[1] = 4'b0110;
    for (int r = 0; r < 2; r++) begin
      p0 = pulses;
      set_fila(rows[r]);
      @(posedge clk); #1 columna = 4'b0001;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        total++;
        if (detener !== 1'b0) begin
          bad++;
          $display("FAIL no_row fila=%b detener got=%b want=0", rows[r], detener);
        end
      end
      columna = 4'd0;
      repeat (3) @(posedge clk);
      total++;
      if (pulses != p0) begin
        bad++;
        $display("FAIL no_row fila=%b pulses got=%0d want=0", rows[r], pulses - p0);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] f, c;
    int d;
    for (int i = 0; i < 20; i++) begin
      f = 4'b0001 << $urandom_range(0, 3);
      c = 4'($urandom_range(1, 15));
      d = $urandom_range(1, 12);
      set_fila(f);
      run_press(f, c, d, "random");
    end
  endtask

  task automatic test_reset_rebote;
    int p0;
    set_fila(4'b1000);
    p0 = pulses;
    @(posedge clk); #1 columna = 4'b0001;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    exp_tecla = 0;
    total++;
    if ({tecla, tecla_valida, detener} !== 6'd0) begin
      bad++;
      $display("FAIL reset_rebote immediate got=%b want=000000", {tecla, tecla_valida, detener});
    end
    columna = 4'd0;
    @(negedge clk) rst = 1'b1;
    repeat (12) @(negedge clk);
    total++;
    if (pulses != p0) begin
      bad++;
      $display("FAIL reset_rebote pulses got=%0d want=0", pulses - p0);
    end
    total++;
    if ({tecla, detener} !== 5'd0) begin
      bad++;
      $display("FAIL reset_rebote after got=%b want=00000", {tecla, detener});
    end
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0; exp_tecla = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_long_hold();
    test_two_keys();
    test_no_row();
    test_random();
    test_reset_rebote();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
